// File: rtl/spi_line_master_if.sv
// Bus bundle for spi_line_master: the transfer request/response side and the
// serial pins. The master modport is the controller's view; the slave modport
// is the view of whoever drives requests and models the remote device.
interface spi_line_master_if #(
    parameter int NBIT = 128,
    parameter int NCS  = 2
);
    localparam int NBW = $clog2(NBIT / 8);
    localparam int CSW = $clog2(NCS);

    // request side
    logic            iSTART;
    logic            iABORT;
    logic [NBIT-1:0] iDATApar;
    logic [NBW-1:0]  iNBYTES;
    logic [1:0]      iMODE;
    logic [CSW-1:0]  iCS;
    logic            iMISO;

    // response side and serial pins
    logic [NBIT-1:0] oDATApar;
    logic            oDONE;
    logic            oBUSY;
    logic            oSCLK;
    logic            oMOSI;
    logic [NCS-1:0]  oSS_n;

    modport master (
        input  iSTART, iABORT, iDATApar, iNBYTES, iMODE, iCS, iMISO,
        output oDATApar, oDONE, oBUSY, oSCLK, oMOSI, oSS_n
    );

    modport slave (
        output iSTART, iABORT, iDATApar, iNBYTES, iMODE, iCS, iMISO,
        input  oDATApar, oDONE, oBUSY, oSCLK, oMOSI, oSS_n
    );
endinterface

// File: rtl/spi_line_master.sv
// SPI master that shifts a whole parallel line out (MSB first) and collects
// the returned bits into a parallel line. One transfer is 1..NBIT/8 bytes in
// any of the four SPI modes, framed by a lead-in and a tail of one SCLK
// half-period each. All outputs come straight from registers.
module spi_line_master #(
    parameter int NBIT    = 128,
    parameter int CLK_DIV = 100,
    parameter int NCS     = 2
) (
    input  logic                iCLK,
    input  logic                iRST,
    spi_line_master_if.master   bus
);
    localparam int NBW = $clog2(NBIT / 8);
    // 16 SCLK edges per byte, up to NBIT/8 bytes: 4 extra bits over NBW
    localparam int HW  = NBW + 4;
    localparam int CSW = $clog2(NCS);
    localparam int DW  = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

    // Active-low one-cold select for the addressed slave; out-of-range
    // indices leave every select deasserted.
    function automatic logic [NCS-1:0] cs_select(input logic [CSW-1:0] idx);
        logic [NCS-1:0] sel;
        sel = {NCS{1'b1}};
        for (int i = 0; i < NCS; i++) begin
            if (CSW'(i) == idx) begin
                sel[i] = 1'b0;
            end
        end
        return sel;
    endfunction

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;     // cycles left in the current SCLK level
    logic [HW-1:0]   half_q, half_d;   // SCLK edges still to come after the first
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [NCS-1:0]  ss_n_q, ss_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NBIT-1:0] dout_q, dout_d;
    logic [NBIT-1:0] tx_q, tx_d;       // next bit to drive sits in the MSB
    logic [NBIT-1:0] rx_q, rx_d;
    logic            cpol_q, cpol_d;
    logic            cpha_q, cpha_d;

    logic            div_zero_s;
    logic            abort_s;
    logic            edge_s;
    logic            lead_edge_s;
    logic            sample_s;
    logic            drive_s;
    logic [NBIT-1:0] rx_shift_s;
    logic [NBIT-1:0] tx_shift_s;

    assign div_zero_s  = (div_q == {DW{1'b0}});
    assign abort_s     = bus.iABORT & (state_q != ST_IDLE);
    // An SCLK edge happens when a level expires at LEAD exit or in XFER while
    // edges remain; the count reaching zero means the last edge is behind us.
    assign edge_s      = ~abort_s & div_zero_s &
                         ((state_q == ST_LEAD) |
                          ((state_q == ST_XFER) & (half_q != {HW{1'b0}})));
    // Moving away from the idle level is the leading edge.
    assign lead_edge_s = (sclk_q == cpol_q);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge drives.
    assign sample_s    = edge_s & (lead_edge_s ^ cpha_q);
    assign drive_s     = edge_s & ~(lead_edge_s ^ cpha_q);
    assign rx_shift_s  = {rx_q[NBIT-2:0], bus.iMISO};
    assign tx_shift_s  = {tx_q[NBIT-2:0], 1'b0};

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        sclk_d  = edge_s ? ~sclk_q : sclk_q;
        mosi_d  = drive_s ? tx_q[NBIT-1] : mosi_q;
        ss_n_d  = ss_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        tx_d    = drive_s ? tx_shift_s : tx_q;
        rx_d    = sample_s ? rx_shift_s : rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;

        if (abort_s) begin
            // Cancel: release the bus at once, keep the last completed line.
            state_d = ST_IDLE;
            div_d   = {DW{1'b0}};
            half_d  = {HW{1'b0}};
            sclk_d  = cpol_q;
            mosi_d  = 1'b1;
            ss_n_d  = {NCS{1'b1}};
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iSTART) begin
                        state_d = ST_LEAD;
                        div_d   = DIV_MAX;
                        half_d  = {bus.iNBYTES, 4'hF};
                        cpol_d  = bus.iMODE[1];
                        cpha_d  = bus.iMODE[0];
                        sclk_d  = bus.iMODE[1];
                        ss_n_d  = cs_select(bus.iCS);
                        busy_d  = 1'b1;
                        rx_d    = {NBIT{1'b0}};
                        if (bus.iMODE[0]) begin
                            // CPHA=1: first bit goes out on the first leading edge
                            tx_d   = bus.iDATApar;
                            mosi_d = 1'b1;
                        end else begin
                            // CPHA=0: first bit must be valid before the first edge
                            tx_d   = {bus.iDATApar[NBIT-2:0], 1'b0};
                            mosi_d = bus.iDATApar[NBIT-1];
                        end
                    end else begin
                        mosi_d = 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (div_zero_s) begin
                        state_d = ST_XFER;
                        div_d   = DIV_MAX;
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end
                ST_XFER: begin
                    if (div_zero_s) begin
                        div_d = DIV_MAX;
                        if (half_q == {HW{1'b0}}) begin
                            state_d = ST_TRAIL;
                        end else begin
                            half_d = half_q - HW'(1);
                        end
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end
                ST_TRAIL: begin
                    if (div_zero_s) begin
                        state_d = ST_IDLE;
                        ss_n_d  = {NCS{1'b1}};
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        dout_d  = rx_q;
                        mosi_d  = 1'b1;
                        sclk_d  = cpol_q;
                    end else begin
                        div_d = div_q - DW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ss_n_d  = {NCS{1'b1}};
                    busy_d  = 1'b0;
                    mosi_d  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset to the idle bus.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            div_q   <= {DW{1'b0}};
            half_q  <= {HW{1'b0}};
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            ss_n_q  <= {NCS{1'b1}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= {NBIT{1'b0}};
            tx_q    <= {NBIT{1'b0}};
            rx_q    <= {NBIT{1'b0}};
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    assign bus.oDATApar = dout_q;
    assign bus.oDONE    = done_q;
    assign bus.oBUSY    = busy_q;
    assign bus.oSCLK    = sclk_q;
    assign bus.oMOSI    = mosi_q;
    assign bus.oSS_n    = ss_n_q;
endmodule

// File: tb/tb_spi_line_master.sv
// Bench for spi_line_master (NBIT=128, CLK_DIV=2, NCS=2). A behavioural SPI
// slave answers on the edge opposite to the sampling edge; expected results
// are derived from the byte count, mode and data words with plain arithmetic.
module tb_spi_line_master;
    localparam int NBIT    = 128;
    localparam int CLK_DIV = 2;
    localparam int NCS     = 2;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic loop_en    = 1'b0;
    logic slave_miso = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [127:0] prev_dout = 128'd0;

    always #5 iCLK = ~iCLK;

    spi_line_master_if #(.NBIT(NBIT), .NCS(NCS)) bus ();

    assign bus.iMISO = loop_en ? bus.oMOSI : slave_miso;

    spi_line_master #(.NBIT(NBIT), .CLK_DIV(CLK_DIV), .NCS(NCS)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus.master)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic arm(input logic [127:0] d, input logic [3:0] nb, input logic [1:0] mode, input logic cs);
        bus.iDATApar = d;
        bus.iNBYTES  = nb;
        bus.iMODE    = mode;
        bus.iCS      = cs;
        bus.iSTART   = 1'b1;
    endtask

    // Runs one transfer whose iSTART is already armed at the current negedge.
    task automatic xfer(input string tag, input logic [127:0] d, input logic [3:0] nb,
                        input logic [1:0] mode, input logic cs, input bit lp,
                        input logic [127:0] s, input int abort_at, input int start_at,
                        input bit chain);
        int n, half_len, limit, done_k, dones, toggles, ss_bad, nsamp;
        logic [127:0] tx_cap, sreg, dout_done, exp_rx;
        logic cpol, cpha, prev_sclk, leading;
        logic [1:0] exp_ss;
        n = int'(nb) + 1;
        half_len = CLK_DIV * (16 * n + 2);
        limit = (abort_at >= 0) ? abort_at + 4 : half_len + 2;
        done_k = -1; dones = 0; toggles = 0; ss_bad = 0; nsamp = 0;
        tx_cap = 128'd0; sreg = s; dout_done = 128'd0;
        cpol = mode[1]; cpha = mode[0];
        exp_ss = cs ? 2'b01 : 2'b10;
        exp_rx = (lp ? d : s) >> (128 - 8 * n);
        loop_en = lp;
        prev_sclk = 1'b0;
        @(posedge iCLK);
        for (int k = 0; k <= limit; k++) begin
            @(negedge iCLK);
            bus.iSTART = (k == start_at) ? 1'b1 : 1'b0;
            if (k == start_at) bus.iCS = ~cs;
            bus.iABORT = (k == abort_at) ? 1'b1 : 1'b0;
            if (k == 0) begin
                check_val({tag, "_busy_at_accept"}, 128'(bus.oBUSY), 128'd1);
                check_val({tag, "_lead_sclk"}, 128'(bus.oSCLK), 128'(cpol));
                prev_sclk = bus.oSCLK;
                if (!cpha) begin
                    slave_miso = sreg[127];
                    sreg = sreg << 1;
                end
            end else if (bus.oSCLK !== prev_sclk) begin
                toggles++;
                leading = (bus.oSCLK != cpol);
                if (leading != cpha) begin
                    tx_cap = {tx_cap[126:0], bus.oMOSI};
                    nsamp++;
                end else begin
                    slave_miso = sreg[127];
                    sreg = sreg << 1;
                end
                prev_sclk = bus.oSCLK;
            end
            if (bus.oBUSY && bus.oSS_n !== exp_ss) ss_bad++;
            if (bus.oDONE) begin
                dones++;
                if (done_k < 0) begin
                    done_k = k;
                    dout_done = bus.oDATApar;
                    check_val({tag, "_ss_at_done"}, 128'(bus.oSS_n), 128'h3);
                    check_val({tag, "_busy_at_done"}, 128'(bus.oBUSY), 128'd0);
                    if (chain) begin
                        arm(d, nb, mode, ~cs);
                        break;
                    end
                end
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                check_val({tag, "_abort_ss"}, 128'(bus.oSS_n), 128'h3);
                check_val({tag, "_abort_busy"}, 128'(bus.oBUSY), 128'd0);
                check_val({tag, "_abort_sclk"}, 128'(bus.oSCLK), 128'(cpol));
                check_val({tag, "_abort_mosi"}, 128'(bus.oMOSI), 128'd1);
                check_val({tag, "_abort_dout"}, bus.oDATApar, prev_dout);
            end
        end
        bus.iABORT = 1'b0;
        check_val({tag, "_ss_while_busy"}, 128'(ss_bad), 128'd0);
        check_val({tag, "_tx_bits"}, tx_cap, d >> (128 - nsamp));
        if (abort_at >= 0) begin
            check_val({tag, "_no_done"}, 128'(dones), 128'd0);
        end else begin
            check_val({tag, "_done_cycle"}, 128'(done_k), 128'(half_len));
            check_val({tag, "_sclk_edges"}, 128'(toggles), 128'(16 * n));
            check_val({tag, "_tx_count"}, 128'(nsamp), 128'(8 * n));
            check_val({tag, "_rx_line"}, dout_done, exp_rx);
            prev_dout = exp_rx;
            if (!chain) begin
                check_val({tag, "_done_pulses"}, 128'(dones), 128'd1);
                check_val({tag, "_idle_ss"}, 128'(bus.oSS_n), 128'h3);
                check_val({tag, "_idle_busy"}, 128'(bus.oBUSY), 128'd0);
                check_val({tag, "_idle_mosi"}, 128'(bus.oMOSI), 128'd1);
                check_val({tag, "_idle_sclk"}, 128'(bus.oSCLK), 128'(cpol));
                check_val({tag, "_dout_hold"}, bus.oDATApar, exp_rx);
            end
        end
    endtask

    initial begin
        logic [127:0] d, s;
        int dones, hi;
        bus.iSTART = 1'b0; bus.iABORT = 1'b0; bus.iDATApar = 128'd0;
        bus.iNBYTES = 4'd0; bus.iMODE = 2'b00; bus.iCS = 1'b0;
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        check_val("rst_dout", bus.oDATApar, 128'd0);
        check_val("rst_done", 128'(bus.oDONE), 128'd0);
        check_val("rst_busy", 128'(bus.oBUSY), 128'd0);
        check_val("rst_sclk", 128'(bus.oSCLK), 128'd0);
        check_val("rst_mosi", 128'(bus.oMOSI), 128'd1);
        check_val("rst_ss", 128'(bus.oSS_n), 128'h3);
        iRST = 1'b0;

        // abort while idle is ignored
        @(negedge iCLK); bus.iABORT = 1'b1;
        @(negedge iCLK); bus.iABORT = 1'b0;
        check_val("idle_abort_busy", 128'(bus.oBUSY), 128'd0);

        // full line, mode 0, loopback
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        @(negedge iCLK); arm(d, 4'd15, 2'b00, 1'b0);
        xfer("m0_full", d, 4'd15, 2'b00, 1'b0, 1'b1, 128'd0, -1, -1, 1'b0);

        // mode 3 single byte, slave returns 0x3C
        d = {8'hA5, 24'd0, $urandom(), $urandom(), $urandom()};
        s = {8'h3C, 24'd0, $urandom(), $urandom(), $urandom()};
        @(negedge iCLK); arm(d, 4'd0, 2'b11, 1'b1);
        xfer("m3_byte", d, 4'd0, 2'b11, 1'b1, 1'b0, s, -1, -1, 1'b0);

        // modes 1 and 2, 0x96 loopback then slave-driven
        d = {8'h96, 120'd0};
        @(negedge iCLK); arm(d, 4'd0, 2'b01, 1'b0);
        xfer("m1_loop", d, 4'd0, 2'b01, 1'b0, 1'b1, 128'd0, -1, -1, 1'b0);
        @(negedge iCLK); arm(d, 4'd0, 2'b10, 1'b1);
        xfer("m2_loop", d, 4'd0, 2'b10, 1'b1, 1'b1, 128'd0, -1, -1, 1'b0);
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge iCLK); arm(d, 4'd1, 2'b01, 1'b0);
        xfer("m1_slave", d, 4'd1, 2'b01, 1'b0, 1'b0, s, -1, -1, 1'b0);
        @(negedge iCLK); arm(d, 4'd1, 2'b10, 1'b0);
        xfer("m2_slave", d, 4'd1, 2'b10, 1'b0, 1'b0, s, -1, -1, 1'b0);

        // second start mid-transfer ignored
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge iCLK); arm(d, 4'd1, 2'b00, 1'b0);
        xfer("start_ignored", d, 4'd1, 2'b00, 1'b0, 1'b1, 128'd0, -1, 10, 1'b0);

        // start in the done cycle is accepted, then runs on the other slave
        @(negedge iCLK); arm(d, 4'd0, 2'b00, 1'b0);
        xfer("chain_a", d, 4'd0, 2'b00, 1'b0, 1'b1, 128'd0, -1, -1, 1'b1);
        xfer("chain_b", d, 4'd0, 2'b00, 1'b1, 1'b1, 128'd0, -1, -1, 1'b0);

        // abort after 5 bits
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge iCLK); arm(d, 4'd1, 2'b00, 1'b0);
        xfer("abort", d, 4'd1, 2'b00, 1'b0, 1'b1, 128'd0, 20, -1, 1'b0);

        // start and abort together while idle: start wins
        @(negedge iCLK); arm(d, 4'd0, 2'b01, 1'b1); bus.iABORT = 1'b1;
        xfer("start_over_abort", d, 4'd0, 2'b01, 1'b1, 1'b1, 128'd0, -1, -1, 1'b0);

        // asynchronous reset mid-transfer
        @(negedge iCLK); arm(d, 4'd3, 2'b11, 1'b1); loop_en = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK); bus.iSTART = 1'b0;
        repeat (30) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check_val("arst_dout", bus.oDATApar, 128'd0);
        check_val("arst_done", 128'(bus.oDONE), 128'd0);
        check_val("arst_busy", 128'(bus.oBUSY), 128'd0);
        check_val("arst_sclk", 128'(bus.oSCLK), 128'd0);
        check_val("arst_mosi", 128'(bus.oMOSI), 128'd1);
        check_val("arst_ss", 128'(bus.oSS_n), 128'h3);
        @(negedge iCLK); iRST = 1'b0;
        prev_dout = 128'd0;
        dones = 0; hi = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge iCLK);
            if (bus.oDONE) dones++;
            if (bus.oSCLK) hi++;
        end
        check_val("arst_no_done", 128'(dones), 128'd0);
        check_val("arst_sclk_low", 128'(hi), 128'd0);
        @(negedge iCLK); arm(d, 4'd2, 2'b00, 1'b0);
        xfer("after_rst", d, 4'd2, 2'b00, 1'b0, 1'b1, 128'd0, -1, -1, 1'b0);

        // randomized transfers
        for (int t = 0; t < 10; t++) begin
            logic [3:0] nb;
            logic [1:0] mode;
            logic cs, lp;
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            nb = 4'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
            cs = 1'($urandom_range(0, 1));
            lp = 1'($urandom_range(0, 1));
            @(negedge iCLK); arm(d, nb, mode, cs);
            xfer($sformatf("rnd%0d", t), d, nb, mode, cs, lp, s, -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_line_master.md
SPI_LINE_MASTER -- requirements
Module: spi_line_master

Interface
REQ-001 SHALL have parameter NBIT, default 128, line width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter CLK_DIV, default 100, SCLK half-period in iCLK cycles; at least 2.
REQ-003 SHALL have parameter NCS, default 2, number of chip selects; at least 2.
REQ-004 SHALL have iCLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have iRST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have iSTART  in  1  single-cycle transfer request.
REQ-007 SHALL have iABORT  in  1  cancel the transfer in progress.
REQ-008 SHALL have iDATApar  in  NBIT  TX line, sampled on the accepted iSTART.
REQ-009 SHALL have iNBYTES  in  clog2(NBIT/8)  value k means k+1 bytes to transfer.
REQ-010 SHALL have iMODE  in  2  {CPOL,CPHA}, sampled on the accepted iSTART.
REQ-011 SHALL have iCS  in  clog2(NCS)  target slave index, sampled on the accepted iSTART.
REQ-012 SHALL have iMISO  in  1  serial input.
REQ-013 SHALL have oDATApar  out  NBIT  RX line, registered.
REQ-014 SHALL have oDONE  out  1  one-cycle pulse when a transfer completes.
REQ-015 SHALL have oBUSY  out  1  high from acceptance until completion or abort.
REQ-016 SHALL have oSCLK, oMOSI  out  1 each  serial clock and serial data output.
REQ-017 SHALL have oSS_n  out  NCS  active-low chip selects.

Function
REQ-018 SHALL implement FSM IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
REQ-019 SHALL accept iSTART only in IDLE; iSTART while oBUSY=1 is ignored, with no queuing.
REQ-020 On acceptance at edge T, SHALL latch the inputs, set oBUSY=1 and drive oSS_n[iCS]=0 from T+1; the other oSS_n bits stay 1.
REQ-021 LEAD SHALL last CLK_DIV cycles with oSCLK=CPOL.
REQ-022 XFER SHALL produce 8*n SCLK periods, where n=iNBYTES+1; each level lasts CLK_DIV cycles and the leading edge comes first.
REQ-023 TX SHALL be MSB first: bits iDATApar[NBIT-1] down to iDATApar[NBIT-8n].
REQ-024 CPHA=0: first bit driven on oMOSI at LEAD entry; iMISO sampled on each leading edge; next bit driven on each trailing edge.
REQ-025 CPHA=1: bit driven on each leading edge; iMISO sampled on each trailing edge.
REQ-026 RX SHALL shift into the LSB of an NBIT register that is cleared at acceptance; after n bytes the data occupies bits [8n-1:0] and the upper bits are 0.
REQ-027 TRAIL SHALL last CLK_DIV cycles after the final SCLK edge with oSCLK=CPOL.
REQ-028 On TRAIL exit, the same cycle SHALL see: oSS_n all 1, oBUSY=0, oDONE=1, and oDATApar updated with the RX register.
REQ-029 oDONE SHALL be high at exactly T + CLK_DIV*(16n+2) + 1.
REQ-030 SHALL be able to accept a new iSTART in the cycle oDONE is high; a transfer accepted there begins LEAD at the next edge.
REQ-031 oMOSI SHALL be 1 in IDLE.
REQ-032 The bit counter SHALL not wrap; the final edge is detected at count 0.
REQ-033 iABORT in LEAD, XFER or TRAIL SHALL, at the next edge: return to IDLE, set oSS_n all 1, oSCLK=CPOL, oMOSI=1, oBUSY=0; produce no oDONE; leave oDATApar unchanged.
REQ-034 iABORT in IDLE SHALL be ignored.
REQ-035 iABORT and iSTART together in IDLE SHALL give START priority.
REQ-036 Inputs other than iMISO and iABORT SHALL be don't-care while oBUSY=1.

Reset
REQ-037 iRST=1 SHALL asynchronously force: IDLE, oDATApar=0, oDONE=0, oBUSY=0, oSCLK=0, oMOSI=1, oSS_n all 1, counters 0.
REQ-038 Reset mid-transfer SHALL abandon the transfer without an oDONE pulse.
REQ-039 After reset, CPOL SHALL be 0 until the first acceptance.

Verification (NBIT=128, CLK_DIV=2, NCS=2)
REQ-040 Mode 0, iNBYTES=15, iDATApar=0x0123456789ABCDEF_FEDCBA9876543210, iMISO looped to oMOSI, iCS=0 -> 128 SCLK periods, oDONE at T+517, oDATApar equal to iDATApar, oSS_n=2'b10 while busy.
REQ-041 Mode 3, iNBYTES=0, iDATApar[127:120]=0xA5, slave returning 0x3C -> oSCLK idle high, 8 periods, oMOSI bits 1,0,1,0,0,1,0,1, oDATApar=0x3C with the upper 120 bits 0, oDONE at T+37.
REQ-042 Mode 1 and mode 2 single byte with 0x96 loopback -> oDATApar[7:0]=0x96; sampling on the trailing (mode 1) and leading (mode 2) edge checked against a reference model.
REQ-043 Second iSTART 10 cycles into a transfer -> ignored, exactly one oDONE; iSTART in the oDONE cycle -> accepted, oSS_n low again at the next edge.
REQ-044 iABORT after 5 bits -> next cycle oSS_n=2'b11, oBUSY=0, no oDONE, oDATApar keeps its previous value.
REQ-045 iRST pulse mid-XFER (asynchronous, between edges) -> outputs take the REQ-037 values immediately, no oDONE, and a following transfer completes normally.
